ex_muldiv_seq: RTL and testbench

Iterative sequencer for unsigned RV32M multiply/divide operations issued from the EX stage. It accepts one operation from ID/EX and holds the pipeline through a stall request while a radix-2 shift-add or restoring-divide datapath iterates. It then presents a registered result for one cycle and releases the stall. Divide-by-zero completes early with the RISC-V defined results.

---
 rtl/ex_muldiv_seq.sv | 141 ++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with stall.
module ex_muldiv_seq #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [REG_WIDTH-1:0] rs1_data,
    input  logic [REG_WIDTH-1:0] rs2_data,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 done,
    output logic [REG_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(REG_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULHU = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_REMU  = 2'd3;

    logic [1:0]             state;
    logic [CNT_W-1:0]       count;
    logic [1:0]             op_q;
    logic [REG_WIDTH-1:0]   operand_q;   // multiplicand for MUL*, divisor for DIV*
    logic [2*REG_WIDTH-1:0] prod_q;
    logic [REG_WIDTH:0]     rem_q;
    logic [REG_WIDTH-1:0]   quo_q;
    logic [REG_WIDTH-1:0]   result_q;
    logic                   done_q;
    logic                   busy_q;

    logic [REG_WIDTH:0]     add_sum;
    logic [2*REG_WIDTH-1:0] prod_nxt;
    logic [REG_WIDTH+1:0]   rem_shift;
    logic [REG_WIDTH+1:0]   trial;
    logic [REG_WIDTH:0]     rem_nxt;
    logic [REG_WIDTH-1:0]   quo_nxt;
    logic [REG_WIDTH-1:0]   final_val;
    logic                   last_iter;

    always_comb begin
        add_sum   = {1'b0, prod_q[2*REG_WIDTH-1:REG_WIDTH]}
                  + (prod_q[0] ? {1'b0, operand_q} : '0);
        prod_nxt  = {add_sum, prod_q[REG_WIDTH-1:1]};
        // rem < divisor always, so the top bit of the trial difference is its sign
        rem_shift = {rem_q, quo_q[REG_WIDTH-1]};
        trial     = rem_shift - {2'b00, operand_q};
        rem_nxt   = trial[REG_WIDTH+1] ? rem_shift[REG_WIDTH:0] : trial[REG_WIDTH:0];
        quo_nxt   = {quo_q[REG_WIDTH-2:0], ~trial[REG_WIDTH+1]};
        last_iter = (count == CNT_W'(REG_WIDTH - 1));
        final_val = '0;
        case (op_q)
            OP_MUL:   final_val = prod_nxt[REG_WIDTH-1:0];
            OP_MULHU: final_val = prod_nxt[2*REG_WIDTH-1:REG_WIDTH];
            OP_DIVU:  final_val = quo_nxt;
            OP_REMU:  final_val = rem_nxt[REG_WIDTH-1:0];
            default:  final_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (flush) begin
            state  <= S_IDLE;
            count  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        operand_q <= op[1] ? rs2_data : rs1_data;
                        prod_q    <= {{REG_WIDTH{1'b0}}, rs2_data};
                        rem_q     <= '0;
                        quo_q     <= rs1_data;
                        count     <= '0;
                        busy_q    <= 1'b1;
                        if (op[1] && (rs2_data == '0)) begin
                            // RISC-V divide-by-zero: quotient all ones, remainder = dividend
                            result_q <= (op == OP_REMU) ? rs1_data : '1;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (op_q[1]) begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                    end else begin
                        prod_q <= prod_nxt;
                    end
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= final_val;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_req = ((state == S_IDLE) && start && !flush) || (state == S_RUN);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq (REG_WIDTH = 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_seq #(.REG_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and follow it until done,
    // then step into the following idle cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit stall_ok);
        res = '0;
        lat = -1;
        stall_ok = 1'b1;
        start = 1'b1; op = o; rs1_data = a; rs2_data = b;
        #1;
        if (!stall_req) stall_ok = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                res = result;
                if (stall_req) stall_ok = 1'b0;
                break;
            end
            if (!stall_req) stall_ok = 1'b0;
            step();
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; bit sok;
        run_op(2'b00, 32'd7, 32'd6, r, lat, sok);
        n_cmp++; if (r !== 32'd42) begin n_err++; $display("FAIL mul_7x6: got %h want %h", r, 32'd42); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", lat); end
        n_cmp++; if (sok !== 1'b1) begin n_err++; $display("FAIL mul_stall_window: got %b want 1", sok); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mul_idle_after: got %b want 0", busy); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, sok);
        n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu_max: got %h want fffffffe", r); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, sok);
        n_cmp++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL mul_max: got %h want 00000001", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat; bit sok;
        run_op(2'b10, 32'd100, 32'd7, r, lat, sok);
        n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_100_7: got %h want %h", r, 32'd14); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
        run_op(2'b11, 32'd100, 32'd7, r, lat, sok);
        n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_100_7: got %h want %h", r, 32'd2); end
        run_op(2'b10, 32'd5, 32'd9, r, lat, sok);
        n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL divu_5_9: got %h want 0", r); end
        run_op(2'b11, 32'd5, 32'd9, r, lat, sok);
        n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL remu_5_9: got %h want %h", r, 32'd5); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; int lat; bit sok;
        run_op(2'b10, 32'h1234, 32'd0, r, lat, sok);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by0: got %h want ffffffff", r); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divu_by0_latency: got %0d want 1", lat); end
        n_cmp++; if (sok !== 1'b1) begin n_err++; $display("FAIL divu_by0_stall: got %b want 1", sok); end
        run_op(2'b11, 32'd5, 32'd0, r, lat, sok);
        n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL remu_by0: got %h want %h", r, 32'd5); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL remu_by0_latency: got %0d want 1", lat); end
    endtask

    // Prior result is 5 from the REMU 5/0 above.
    task automatic test_flush();
        logic [31:0] r; int lat; bit sok; bit saw_done;
        saw_done = 1'b0;
        start = 1'b1; op = 2'b00; rs1_data = 32'd3; rs2_data = 32'd5;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall_req); end
        for (int c = 0; c < 30; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", saw_done); end
        n_cmp++; if (result !== 32'd5) begin n_err++; $display("FAIL flush_result_kept: got %h want %h", result, 32'd5); end
        run_op(2'b10, 32'd9, 32'd3, r, lat, sok);
        n_cmp++; if (r !== 32'd3) begin n_err++; $display("FAIL divu_after_flush: got %h want %h", r, 32'd3); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1; logic [31:0] r2; int l1; int l2; bit s1; bit s2;
        run_op(2'b00, 32'h0001_0000, 32'h0003_0000, r1, l1, s1);
        run_op(2'b01, 32'h0001_0000, 32'h0003_0000, r2, l2, s2);
        n_cmp++; if (r1 !== 32'h0) begin n_err++; $display("FAIL b2b_mul_low: got %h want 0", r1); end
        n_cmp++; if (r2 !== 32'h3) begin n_err++; $display("FAIL b2b_mulhu: got %h want 3", r2); end
        n_cmp++; if (l2 !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", l2); end
    endtask

    task automatic test_ignored_start();
        logic [31:0] r; int lat;
        r = '0; lat = -1;
        start = 1'b1; op = 2'b10; rs1_data = 32'd100; rs2_data = 32'd7;
        step();
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin lat = c; r = result; break; end
            if (c == 5) begin
                start = 1'b1; op = 2'b00; rs1_data = 32'd2; rs2_data = 32'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL ignored_start_result: got %h want %h", r, 32'd14); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignored_start_latency: got %0d want 33", lat); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_start_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat; bit sok;
        start = 1'b1; op = 2'b00; rs1_data = 32'd9; rs2_data = 32'd9;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", done); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL midreset_stall: got %b want 0", stall_req); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midreset_result: got %h want 0", result); end
        run_op(2'b00, 32'd3, 32'd4, r, lat, sok);
        n_cmp++; if (r !== 32'd12) begin n_err++; $display("FAIL mul_after_reset: got %h want %h", r, 32'd12); end
    endtask

    initial begin
        #1;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
